w4a8_job_arbiter: RTL and testbench
===================================

# w4a8_job_arbiter

Shares the single W4A8 GEMM engine (tile controller plus GEMM datapath) between NUM_REQ independent job sources.
- Each job is one full GEMM command: op code, M/N/K, and activation/weight/result pointers.
- Jobs are granted round-robin and launched with a start pulse; the block waits for the engine's done pulse and returns a per-requester response.
- A watchdog converts a hung engine into an error response, so one stuck job cannot deadlock the other requesters.

## Interface
Parameters:
- NUM_REQ, 2 — number of requesters, legal range 2..8.
- TIMEOUT_CYC, 0 — watchdog limit in cycles from eng_start; 0 disables the watchdog.

Ports:
- ap_clk  in  1  — the only clock.
- areset  in  1  — synchronous, active-high reset.
- req_valid  in  NUM_REQ  — job offered by requester i.
- req_ready  out  NUM_REQ  — job of requester i accepted this cycle; at most one bit set.
- req_cmd  in  NUM_REQ*CMD_W  — packed gemm_cmd_t per requester; slice i belongs to requester i.
- rsp_valid  out  NUM_REQ  — completion response for requester i; at most one bit set.
- rsp_ready  in  NUM_REQ  — requester i consumes its response.
- rsp_err  out  1  — qualifies the active rsp_valid bit: 1 = rejected or timed-out job.
- eng_start  out  1  — one-cycle launch pulse to the engine.
- eng_cmd  out  CMD_W  — latched command, stable from eng_start until the cycle after the job completes.
- eng_done  in  1  — one-cycle completion pulse from the engine.
- busy  out  1  — state is not IDLE.
- grant_id  out  $clog2(NUM_REQ)  — requester owning the current job.

## Operation
State machine IDLE, START, WAIT, RESP.
- IDLE: if any req_valid is set, the round-robin winner gets req_ready=1 for this cycle only.
  - req_ready is combinational from req_valid and the state.
  - The block latches the winner's cmd into eng_cmd and the winner's index into grant_id.
- Leaving IDLE after accept:
  - If the command has M, N or K equal to 0, go to RESP with err=1 and never pulse eng_start.
  - Otherwise go to START.
- START: eng_start=1, watchdog counter cleared, then go to WAIT.
- WAIT:
  - eng_done=1 → RESP with err=0.
  - Otherwise, if TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC → RESP with err=1.
  - eng_done and timeout in the same cycle → done wins, err=0.
- RESP: rsp_valid[grant_id]=1 and rsp_err held stable until rsp_ready[grant_id]; then go to IDLE.
- Round-robin pointer:
  - Priority starts at last_grant+1 modulo NUM_REQ.
  - The pointer updates only on accept; it also updates for rejected zero-size jobs.
- eng_done outside WAIT is ignored. This includes a late done arriving after a timeout.
- Requesters must hold req_valid and req_cmd stable until accepted; the block does not check this.
- Watchdog counter is 32 bits and saturates at its maximum value, never wrapping.

## Timing
- Reset: all outputs are 0 (req_ready, rsp_valid, rsp_err, eng_start, eng_cmd, busy, grant_id); RR pointer is 0.
  - With the pointer at 0, requester 0 has first priority.
  - State is IDLE and the counter is 0.
- Reset mid-job abandons the job: no response is ever issued for it, and the engine is not notified.
- Accept in cycle T (req_valid&req_ready):
  - eng_start is high in T+1.
  - busy and grant_id are valid from T+1.
- eng_done in cycle D: rsp_valid is high from D+1.
- rsp_ready in cycle R: IDLE in R+1, so the earliest next accept is R+1.
- Zero-size job accepted in T: rsp_valid high in T+1, err=1.
- Timeout with eng_start in cycle S: response begins in cycle S+TIMEOUT_CYC+1.
- Throughput is at most one job per (engine latency + 3) cycles.

## Structure
- Package w4a8_pkg holds:
  - gemm_cmd_t: op_code[31:0], m, n, k[31:0], act_ptr, wgt_ptr, res_ptr[63:0].
  - CMD_W = 320.
  - arb_state_t enum.
- Sub-module w4a8_rr_arb: NUM_REQ request vector plus pointer in, one-hot grant out, purely combinational.
- Top contains the FSM, command/grant registers, RR pointer and watchdog counter.

## Test plan
- Single job, requester 0, M=N=K=64, engine done 10 cycles after start:
  - eng_start exactly 1 cycle after accept, eng_cmd equals req_cmd.
  - rsp_valid[0] 11 cycles after accept, err=0.
- Both requesters valid continuously, 4 jobs:
  - Grants alternate 0,1,0,1.
  - Each req_ready is a single-cycle pulse.
- Requester 1 submits K=0: rsp_valid[1] the cycle after accept, err=1, eng_start never pulses.
- TIMEOUT_CYC=20, engine never signals done:
  - Error response 21 cycles after eng_start.
  - A late eng_done pulse while IDLE causes no state change.
- rsp_ready held low 15 cycles with requester 0 valid:
  - rsp_valid and rsp_err stay stable.
  - No new accept until the cycle after rsp_ready.
- areset asserted in WAIT: next cycle all outputs are 0 and busy=0; the next job goes to requester 0 first.

Source files
------------

// File: rtl/w4a8_pkg.sv
// ---------------------------------------------------------------------------
// w4a8_pkg
// Shared types for the W4A8 GEMM job arbiter.
//   gemm_cmd_t   : one complete GEMM command (op code, M/N/K, three pointers)
//   CMD_W        : packed width of gemm_cmd_t
//   arb_state_t  : arbiter FSM states
//   is_zero_size : true when a command has no work (M, N or K equal to 0)
// ---------------------------------------------------------------------------
package w4a8_pkg;

  localparam int CMD_W = 320;

  // The first field is the MSB end of the packed vector.
  typedef struct packed {
    logic [31:0] op_code;
    logic [31:0] m;
    logic [31:0] n;
    logic [31:0] k;
    logic [63:0] act_ptr;
    logic [63:0] wgt_ptr;
    logic [63:0] res_ptr;
  } gemm_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  function automatic logic is_zero_size(input gemm_cmd_t cmd);
    return (cmd.m == 32'd0) || (cmd.n == 32'd0) || (cmd.k == 32'd0);
  endfunction

endpackage

// File: rtl/w4a8_rr_arb.sv
// ---------------------------------------------------------------------------
// w4a8_rr_arb
// Purely combinational round-robin picker. The search starts at index ptr
// and wraps modulo NUM_REQ; the first requesting index wins.
// Ports:
//   req  in  NUM_REQ          request vector
//   ptr  in  $clog2(NUM_REQ)  index with highest priority this cycle
//   gnt  out NUM_REQ          one-hot grant, all zero when req is zero
// ---------------------------------------------------------------------------
module w4a8_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] idx;
  int               slot;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    slot  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = int'(ptr) + i;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      idx = IDX_W'(slot);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/w4a8_job_arbiter.sv
// ---------------------------------------------------------------------------
// w4a8_job_arbiter
// Shares one W4A8 GEMM engine between NUM_REQ job sources. Jobs are granted
// round-robin, launched with eng_start, and answered with a per-requester
// response once eng_done arrives. Zero-size jobs are answered with an error
// without touching the engine; an optional watchdog turns a hung engine
// into an error response.
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   TIMEOUT_CYC  watchdog limit in cycles from eng_start, 0 = disabled
// Ports:
//   ap_clk, areset        clock, synchronous active-high reset
//   req_valid/req_ready   per-requester job handshake (ready is combinational)
//   req_cmd               packed gemm_cmd_t per requester, slice i = requester i
//   rsp_valid/rsp_ready   per-requester completion handshake
//   rsp_err               qualifies the active rsp_valid bit (1 = rejected/timeout)
//   eng_start/eng_cmd     launch pulse and latched command to the engine
//   eng_done              completion pulse from the engine
//   busy, grant_id        FSM not idle, owner of the current job
// ---------------------------------------------------------------------------
module w4a8_job_arbiter
  import w4a8_pkg::*;
#(
  parameter int          NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic                       rsp_err,
  output logic                       eng_start,
  output logic [CMD_W-1:0]           eng_cmd,
  input  logic                       eng_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int          IDX_W       = $clog2(NUM_REQ);
  localparam logic [31:0] CNT_MAX     = '1;
  localparam logic [31:0] TIMEOUT_LIM = TIMEOUT_CYC;

  arb_state_t           state_q, state_d;
  gemm_cmd_t            cmd_q, cmd_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_W-1:0]     win_idx;
  gemm_cmd_t            win_cmd;
  logic                 accept;
  logic [31:0]          cnt_inc;
  logic                 timeout_hit;

  w4a8_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // Gating with areset keeps the combinational ready at 0 during reset,
  // so no job can be accepted in a cycle whose state is being discarded.
  assign req_ready = (state_q == IDLE && !areset) ? gnt : '0;
  assign accept    = |req_ready;

  // One-hot grant to index plus the matching command slice.
  always_comb begin
    win_idx = '0;
    win_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_idx = IDX_W'(i);
        win_cmd = req_cmd[i*CMD_W +: CMD_W];
      end
    end
  end

  // Saturating increment; the watchdog compares the value the counter is
  // about to take, so a job started in cycle S times out in S+TIMEOUT_CYC
  // and answers in the following cycle.
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 32'd1;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc >= TIMEOUT_LIM);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d   = win_cmd;
          grant_d = win_idx;
          ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          if (is_zero_size(win_cmd)) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d   = START;
            rsp_err_d = 1'b0;
          end
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A done in the same cycle as the timeout wins.
        if (eng_done) begin
          state_d   = RESP;
          rsp_err_d = 1'b0;
        end else if (timeout_hit) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          state_d   = IDLE;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    start_d     = (state_d == START);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = '0;
    if (state_d == RESP) rsp_valid_d[grant_d] = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign eng_start = start_q;
  assign eng_cmd   = cmd_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_w4a8_job_arbiter.sv
// ---------------------------------------------------------------------------
// tb_w4a8_job_arbiter
// Directed bench for w4a8_job_arbiter with NUM_REQ=2, TIMEOUT_CYC=20.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The engine model raises eng_done in the 10th cycle of a job counting the
// eng_start cycle as the first (eng_lat=9 cycles after eng_start), so the
// response lands 11 cycles after accept; eng_lat=0 models a hung engine.
// ---------------------------------------------------------------------------
module tb_w4a8_job_arbiter;
  import w4a8_pkg::*;

  localparam int NR = 2;
  localparam int TO = 20;

  logic              ap_clk = 1'b0;
  logic              areset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*CMD_W-1:0] req_cmd;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic              rsp_err;
  logic              eng_start;
  logic [CMD_W-1:0]  eng_cmd;
  logic              eng_done = 1'b0;
  logic              busy;
  logic [0:0]        grant_id;

  always #5 ap_clk = ~ap_clk;

  w4a8_job_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .eng_start (eng_start),
    .eng_cmd   (eng_cmd),
    .eng_done  (eng_done),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [CMD_W-1:0] got,
                       input logic [CMD_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model
  int   eng_lat    = 9;
  int   eng_cnt    = 0;
  logic force_done = 1'b0;

  always @(negedge ap_clk) begin
    #2;
    eng_done = force_done;
    if (areset) eng_cnt = 0;
    else if (eng_start && eng_lat != 0) eng_cnt = eng_lat;
    else if (eng_cnt != 0) begin
      eng_cnt--;
      if (eng_cnt == 0) eng_done = 1'b1;
    end
  end

  function automatic gemm_cmd_t mk_cmd(input logic [31:0] op, input logic [31:0] m,
                                       input logic [31:0] n, input logic [31:0] k,
                                       input logic [63:0] base);
    gemm_cmd_t c;
    c.op_code = op;
    c.m       = m;
    c.n       = n;
    c.k       = k;
    c.act_ptr = base;
    c.wgt_ptr = base + 64'h1000;
    c.res_ptr = base + 64'h2000;
    return c;
  endfunction

  task automatic set_cmd(input int i, input gemm_cmd_t c);
    req_cmd[i*CMD_W +: CMD_W] = c;
  endtask

  gemm_cmd_t   c0, c1, cz;
  int          n, bad, bad_v, bad_e, bad_r;
  logic [1:0]  exp_g;

  // Wait (bounded) for a response; n = cycles waited.
  task automatic wait_rsp(input int budget);
    n = 0;
    while (rsp_valid == '0 && n < budget) begin
      @(negedge ap_clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    areset    = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_cmd   = '0;
    c0 = mk_cmd(32'h1, 32'd64, 32'd64, 32'd64, 64'h1000_0000);
    c1 = mk_cmd(32'h2, 32'd32, 32'd16, 32'd128, 64'h2000_0000);
    cz = mk_cmd(32'h3, 32'd8, 32'd8, 32'd0, 64'h3000_0000);

    // Reset state
    repeat (3) @(negedge ap_clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_cmd", eng_cmd, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    @(negedge ap_clk);
    areset = 1'b0;
    #1;

    // Single job, requester 0
    @(negedge ap_clk);
    set_cmd(0, c0);
    req_valid = 2'b01;
    #1;
    check("t1_accept", req_ready, 2'b01);
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    check("t1_eng_start", eng_start, 1);
    check("t1_eng_cmd", eng_cmd, c0);
    check("t1_busy", busy, 1);
    check("t1_grant_id", grant_id, 0);
    wait_rsp(40);
    check("t1_rsp_latency", n, 10);
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_cmd_held", eng_cmd, c0);
    rsp_ready = 2'b01;
    @(negedge ap_clk);
    rsp_ready = '0;
    #1;
    check("t1_idle_busy", busy, 0);
    check("t1_idle_rsp", rsp_valid, 0);

    // Zero-size job from requester 1 (pointer now at 1)
    @(negedge ap_clk);
    set_cmd(1, cz);
    req_valid = 2'b10;
    #1;
    check("t3_accept", req_ready, 2'b10);
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    check("t3_rsp_valid", rsp_valid, 2'b10);
    check("t3_rsp_err", rsp_err, 1);
    check("t3_no_start", eng_start, 0);
    check("t3_grant_id", grant_id, 1);
    @(negedge ap_clk);
    #1;
    check("t3_no_start2", eng_start, 0);
    check("t3_rsp_held", rsp_valid, 2'b10);
    rsp_ready = 2'b10;
    @(negedge ap_clk);
    rsp_ready = '0;
    #1;
    check("t3_idle", busy, 0);

    // Both requesters valid continuously: grants 0,1,0,1
    for (int j = 0; j < 4; j++) begin
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge ap_clk);
      rsp_ready = '0;
      if (j == 0) begin
        set_cmd(0, c0);
        set_cmd(1, c1);
        req_valid = 2'b11;
      end
      #1;
      check($sformatf("t2_grant%0d", j), req_ready, exp_g);
      @(negedge ap_clk);
      #1;
      check($sformatf("t2_pulse%0d", j), req_ready, 0);
      check($sformatf("t2_cmd%0d", j), eng_cmd, (j % 2 == 0) ? c0 : c1);
      wait_rsp(40);
      check($sformatf("t2_lat%0d", j), n, 10);
      check($sformatf("t2_rsp%0d", j), rsp_valid, exp_g);
      rsp_ready = exp_g;
    end
    @(negedge ap_clk);
    rsp_ready = '0;
    req_valid = '0;
    #1;
    check("t2_idle", busy, 0);

    // Hung engine, watchdog at 20 cycles (pointer at 0)
    eng_lat = 0;
    @(negedge ap_clk);
    set_cmd(0, c0);
    req_valid = 2'b01;
    #1;
    check("t4_accept", req_ready, 2'b01);
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    check("t4_eng_start", eng_start, 1);
    wait_rsp(60);
    check("t4_timeout_latency", n, TO + 1);
    check("t4_rsp_valid", rsp_valid, 2'b01);
    check("t4_rsp_err", rsp_err, 1);
    rsp_ready = 2'b01;
    @(negedge ap_clk);
    rsp_ready = '0;
    #1;
    check("t4_idle", busy, 0);
    @(negedge ap_clk);
    force_done = 1'b1;
    #1;
    @(negedge ap_clk);
    force_done = 1'b0;
    #1;
    check("t4_late_done_busy", busy, 0);
    check("t4_late_done_rsp", rsp_valid, 0);
    check("t4_late_done_start", eng_start, 0);
    eng_lat = 9;

    // Response back-pressure for 15 cycles with requester 0 waiting
    @(negedge ap_clk);
    set_cmd(1, c1);
    req_valid = 2'b10;
    #1;
    check("t5_accept1", req_ready, 2'b10);
    @(negedge ap_clk);
    set_cmd(0, c0);
    req_valid = 2'b01;
    #1;
    check("t5_busy_no_ready", req_ready, 0);
    wait_rsp(40);
    check("t5_rsp_valid", rsp_valid, 2'b10);
    bad_v = 0;
    bad_e = 0;
    bad_r = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge ap_clk);
      #1;
      if (rsp_valid !== 2'b10) bad_v++;
      if (rsp_err !== 1'b0) bad_e++;
      if (req_ready !== 2'b00) bad_r++;
    end
    check("t5_rsp_valid_stable", bad_v, 0);
    check("t5_rsp_err_stable", bad_e, 0);
    check("t5_no_accept_held", bad_r, 0);
    @(negedge ap_clk);
    rsp_ready = 2'b10;
    #1;
    check("t5_no_accept_in_R", req_ready, 0);
    @(negedge ap_clk);
    rsp_ready = '0;
    #1;
    check("t5_accept_R_plus_1", req_ready, 2'b01);

    // Reset while the job from requester 0 sits in WAIT
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    check("t6_eng_start", eng_start, 1);
    @(negedge ap_clk);
    #1;
    check("t6_busy_wait", busy, 1);
    @(negedge ap_clk);
    areset = 1'b1;
    #1;
    @(negedge ap_clk);
    areset = 1'b0;
    #1;
    check("t6_req_ready", req_ready, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_rsp_err", rsp_err, 0);
    check("t6_eng_start0", eng_start, 0);
    check("t6_eng_cmd", eng_cmd, 0);
    check("t6_busy", busy, 0);
    check("t6_grant_id", grant_id, 0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge ap_clk);
      #1;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) bad++;
    end
    check("t6_no_rsp_abandoned", bad, 0);
    @(negedge ap_clk);
    set_cmd(0, c0);
    set_cmd(1, c1);
    req_valid = 2'b11;
    #1;
    check("t6_first_after_reset", req_ready, 2'b01);
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    wait_rsp(40);
    check("t6_rsp", rsp_valid, 2'b01);
    rsp_ready = 2'b01;
    @(negedge ap_clk);
    rsp_ready = '0;
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
